// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, programmable thresholds, flush and sticky error flags.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads; undefined gives a registered read.
module sync_fifo_ext #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_next_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  afull_r;
  logic                  aempty_r;
  logic                  ovf_r;
  logic                  unf_r;
  logic                  rd_acc_s;
  logic                  wr_acc_s;

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Accept decisions and next occupancy from the registered flags.
  always_comb begin
    rd_acc_s     = rd_en & ~empty_r;
    wr_acc_s     = wr_en & (~full_r | rd_acc_s);
    count_next_s = count_r;
    if (wr_acc_s && !rd_acc_s) begin
      count_next_s = count_r + CW'(1);
    end else if (rd_acc_s && !wr_acc_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointer, occupancy, flag and sticky-error registers.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r  <= count_next_s;
      full_r   <= (count_next_s == CW'(DEPTH));
      empty_r  <= (count_next_s == {CW{1'b0}});
      afull_r  <= (count_next_s >= CW'(AFULL_THRESH));
      aempty_r <= (count_next_s <= CW'(AEMPTY_THRESH));
      ovf_r    <= ovf_r | (wr_en & ~wr_acc_s);
      unf_r    <= unf_r | (rd_en & ~rd_acc_s);
    end
  end

  // Storage array; contents deliberately survive reset and flush.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word shown combinationally; rd_en only pops it.
  assign rd_data  = empty_r ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign rd_valid = ~empty_r;
`else
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

  // Registered read: word appears one cycle after the accepted pop.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else if (rd_acc_s) begin
      rd_data_r  <= mem_r[rd_ptr_r];
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
`endif

  assign count        = count_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO. Adds arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, read-while-full acceptance, synchronous flush, sticky overflow/underflow flags and a compile-time first-word-fall-through read mode. It sits between producer/consumer blocks in a single clock domain, e.g. stream buffering ahead of a serialiser.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 16, number of entries (≥2, any integer, power of two not required)
- AFULL_THRESH, DEPTH-2, almost_full asserts when count ≥ this (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserts when count ≤ this (0..DEPTH-1)
- CW (localparam), $clog2(DEPTH+1), count width

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents and sticky flags
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_THRESH
- rd_en  in  1  read request (pop)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data holds a valid word (see Operation)
- empty  out  1  count == 0
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  CW  current occupancy 0..DEPTH
- overflow  out  1  sticky: a write was attempted while not accepted
- underflow  out  1  sticky: a read was attempted while not accepted

## Operation
- Storage: DEPTH-entry array; wr_ptr/rd_ptr range 0..DEPTH-1, wrap DEPTH-1 → 0 (explicit compare, not bit truncation). Flags derived from count register only.
- Accept rules, evaluated on pre-edge state: rd_acc = rd_en & !empty; wr_acc = wr_en & (!full | rd_acc). A write while full is accepted only if a read is accepted in the same cycle. A read while empty is never accepted, even with a simultaneous write.
- count: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- overflow sets on wr_en & !wr_acc; underflow sets on rd_en & !rd_acc; both stay set until reset or flush.
- Priority: rst_n low > flush > normal operation. Flush: pointers, count, rd_valid, rd_data, overflow, underflow → 0; wr_en/rd_en in the flush cycle are ignored and do not set sticky flags. Memory contents are not cleared.
- Standard mode (macro undefined): on rd_acc, rd_data ← mem[rd_ptr] registered and rd_valid ← 1 the next cycle; otherwise rd_valid ← 0 and rd_data holds its value.

## Timing
- Reset (rst_n low at an edge): count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, pointers=0. Outputs are unchanged until the clock edge.
- Flags and count update on the edge following the accepted operation; no combinational path from wr_en/rd_en to any flag.
- Standard read latency: 1 cycle from the rd_en sample edge to rd_data/rd_valid. Back-to-back rd_en gives one word per cycle.
- Write-to-read: a word written at edge N can be popped at edge N+1 at the earliest (empty drops after N).
- Full + rd_en + wr_en: count stays DEPTH, the write lands in the freed slot, and overflow is not set.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through. rd_data = mem[rd_ptr] combinationally when !empty, 0 when empty; rd_valid = !empty; rd_en acknowledges/pops the shown word. The first write to an empty FIFO is visible on rd_data after the write edge (0-cycle read latency). Accept, count and sticky rules are unchanged.
- Undefined: standard registered read, as in Operation.

## Test plan
- Reset then idle: empty=1, almost_empty=1, count=0, rd_valid=0, rd_data=0, overflow=underflow=0.
- DEPTH=12: write 0x00..0x0B, then read 12 words → data returned in order 0x00..0x0B, full asserts after the 12th write, and pointers wrap cleanly over a second 12-word pass.
- Fill to DEPTH and assert wr_en+rd_en for 4 cycles with wr_data 0xA0..0xA3 → count stays 12, overflow=0, and the drain returns the original words then 0xA0..0xA3.
- Write 1 more on full → overflow=1 and count unchanged. Pulse rd_en while empty → underflow=1. Pulse flush → both flags 0, count=0.
- Threshold sweep with AFULL_THRESH=10, AEMPTY_THRESH=2 → almost_full rises on the edge count reaches 10, and almost_empty falls on the edge count reaches 3.
- FWFT build: write 0x5A to empty → rd_data=0x5A, rd_valid=1 the next cycle without rd_en. rd_en pops it → empty=1, rd_data=0.
